// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding, image-format constants and helpers for the program loader
package loader_pkg;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_HDR_I,
    ST_DATA_I,
    ST_HDR_D,
    ST_DATA_D,
    ST_FINISH,
    ST_ERR
  } load_state_e;

  // Image format: little-endian 16-bit word count, then that many 32-bit words, LSB first.
  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;
  localparam int BYTE_W     = 8;
  localparam int WORD_W     = BYTE_W * WORD_BYTES;
  localparam int COUNT_W    = BYTE_W * HDR_BYTES;

  // A region may hold at most 2^aw words; exactly 2^aw fills it and is legal.
  function automatic logic count_too_big(input logic [COUNT_W-1:0] cnt, input int aw);
    logic [COUNT_W:0] limit;
    limit = (COUNT_W+1)'(1) << aw;
    return {1'b0, cnt} > limit;
  endfunction

endpackage

// File: rtl/word_assembler.sv
// rtl/word_assembler.sv - packs a little-endian byte stream into 32-bit words
//   clock, reset      : clock, asynchronous active-low reset
//   clear             : restart word assembly at byte 0 (priority over byte_valid)
//   byte_valid/data   : incoming byte strobe and value
//   word_valid/data   : combinational pulse with the completed word on the 4th byte
module word_assembler
  import loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_data
);

  localparam int CNT_W = $clog2(WORD_BYTES);
  localparam int SHR_W = WORD_W - BYTE_W;

  logic [CNT_W-1:0] byte_cnt_q;
  logic [SHR_W-1:0] shreg_q;

  // The final byte is merged straight from the input so the word is
  // available in the same cycle it completes; only three bytes are stored.
  assign word_valid = byte_valid && (byte_cnt_q == CNT_W'(WORD_BYTES - 1));
  assign word_data  = {byte_data, shreg_q};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      byte_cnt_q <= '0;
      shreg_q    <= '0;
    end else if (clear) begin
      byte_cnt_q <= '0;
      shreg_q    <= '0;
    end else if (byte_valid) begin
      byte_cnt_q <= byte_cnt_q + CNT_W'(1);
      shreg_q    <= {byte_data, shreg_q[SHR_W-1:BYTE_W]};
    end
  end

endmodule

// File: rtl/mem_load_arbiter.sv
// rtl/mem_load_arbiter.sv - memory write-port arbiter with UART program loader
//   clock, reset                 : clock, asynchronous active-low reset
//   prog_req                     : start a load on its rising edge (from RUN or ERR)
//   rx_valid, rx_byte            : received UART byte stream
//   cpu_mem_write/addr/wdata     : CPU data-memory write, passed through in RUN
//   cpu_hold, cpu_restart        : CPU freeze level and PC-to-zero pulse
//   imem_we/addr/wdata           : instruction-memory write port (word address)
//   dmem_we/addr/wdata           : data-memory write port (byte address)
//   load_busy, load_done, load_err : loader status
module mem_load_arbiter
  import loader_pkg::*;
#(
  parameter int IMEM_AW     = 14,
  parameter int DMEM_AW     = 14,
  parameter int TIMEOUT_CYC = 10_000_000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               prog_req,
  input  logic               rx_valid,
  input  logic [7:0]         rx_byte,
  input  logic               cpu_mem_write,
  input  logic [31:0]        cpu_mem_addr,
  input  logic [31:0]        cpu_mem_wdata,
  output logic               cpu_hold,
  output logic               cpu_restart,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               dmem_we,
  output logic [31:0]        dmem_addr,
  output logic [31:0]        dmem_wdata,
  output logic               load_busy,
  output logic               load_done,
  output logic               load_err
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  load_state_e        state_q, state_d;
  logic               prog_q, prog_edge, start;
  logic               hdr_state, data_state, loading, hdr_last, timeout;
  logic               hdr_phase_q;
  logic [BYTE_W-1:0]  hdr_lo_q;
  logic [COUNT_W-1:0] hdr_count, word_cnt_q, word_idx_q, idx_next;
  logic [TMR_W-1:0]   idle_q;
  logic               wa_clear, word_valid;
  logic [WORD_W-1:0]  word_data;
  logic               imem_we_q, dmem_we_q, load_err_q;
  logic [IMEM_AW-1:0] imem_addr_q;
  logic [31:0]        imem_wdata_q, dmem_addr_q, dmem_wdata_q;

  assign prog_edge  = prog_req & ~prog_q;
  assign hdr_state  = (state_q == ST_HDR_I) || (state_q == ST_HDR_D);
  assign data_state = (state_q == ST_DATA_I) || (state_q == ST_DATA_D);
  assign loading    = hdr_state || data_state;
  assign hdr_last   = hdr_state && rx_valid && hdr_phase_q;
  assign hdr_count  = {rx_byte, hdr_lo_q};
  assign idx_next   = word_idx_q + COUNT_W'(1);
  assign timeout    = loading && !rx_valid && (idle_q == TMR_LAST);

  // Every state change restarts word assembly so a partial word never leaks
  // across regions, errors or a fresh load.
  assign wa_clear = (state_d != state_q);

  word_assembler u_word_assembler (
    .clock      (clock),
    .reset      (reset),
    .clear      (wa_clear),
    .byte_valid (rx_valid && data_state),
    .byte_data  (rx_byte),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    start       = 1'b0;
    cpu_hold    = (state_q != ST_RUN);
    cpu_restart = 1'b0;
    load_done   = 1'b0;
    load_busy   = loading;
    case (state_q)
      ST_RUN: begin
        if (prog_edge) begin
          state_d = ST_HDR_I;
          start   = 1'b1;
        end
      end
      ST_HDR_I, ST_HDR_D: begin
        if (hdr_last) begin
          if (count_too_big(hdr_count, (state_q == ST_HDR_I) ? IMEM_AW : DMEM_AW))
            state_d = ST_ERR;
          else if (hdr_count == '0)
            state_d = (state_q == ST_HDR_I) ? ST_HDR_D : ST_FINISH;
          else
            state_d = (state_q == ST_HDR_I) ? ST_DATA_I : ST_DATA_D;
        end else if (timeout) begin
          state_d = ST_ERR;
        end
      end
      ST_DATA_I, ST_DATA_D: begin
        if (word_valid && (idx_next == word_cnt_q))
          state_d = (state_q == ST_DATA_I) ? ST_HDR_D : ST_FINISH;
        else if (timeout)
          state_d = ST_ERR;
      end
      ST_FINISH: begin
        state_d     = ST_RUN;
        cpu_restart = 1'b1;
        load_done   = 1'b1;
        load_busy   = 1'b1;
      end
      ST_ERR: begin
        if (prog_edge) begin
          state_d = ST_HDR_I;
          start   = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prog_q       <= 1'b0;
      hdr_phase_q  <= 1'b0;
      hdr_lo_q     <= '0;
      word_cnt_q   <= '0;
      word_idx_q   <= '0;
      idle_q       <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      load_err_q   <= 1'b0;
    end else begin
      prog_q    <= prog_req;
      imem_we_q <= 1'b0;
      dmem_we_q <= 1'b0;

      if (state_d != state_q) begin
        hdr_phase_q <= 1'b0;
        word_idx_q  <= '0;
      end else begin
        // The second header byte always changes state, so only the first lands here.
        if (hdr_state && rx_valid) begin
          hdr_phase_q <= 1'b1;
          hdr_lo_q    <= rx_byte;
        end
        if (word_valid) word_idx_q <= idx_next;
      end

      if (hdr_last) word_cnt_q <= hdr_count;

      if (word_valid) begin
        if (state_q == ST_DATA_I) begin
          imem_we_q    <= 1'b1;
          imem_addr_q  <= word_idx_q[IMEM_AW-1:0];
          imem_wdata_q <= word_data;
        end else begin
          dmem_we_q    <= 1'b1;
          dmem_addr_q  <= {{(32-COUNT_W-2){1'b0}}, word_idx_q, 2'b00};
          dmem_wdata_q <= word_data;
        end
      end

      idle_q <= (loading && !rx_valid) ? idle_q + TMR_W'(1) : '0;

      if (start)                  load_err_q <= 1'b0;
      else if (state_d == ST_ERR) load_err_q <= 1'b1;
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign load_err   = load_err_q;

  // The CPU owns the data port only while running; otherwise the loader does.
  always_comb begin
    if (state_q == ST_RUN) begin
      dmem_we    = cpu_mem_write;
      dmem_addr  = cpu_mem_addr;
      dmem_wdata = cpu_mem_wdata;
    end else begin
      dmem_we    = dmem_we_q;
      dmem_addr  = dmem_addr_q;
      dmem_wdata = dmem_wdata_q;
    end
  end

endmodule

// File: tb/tb_mem_load_arbiter.sv
// tb/tb_mem_load_arbiter.sv - table-driven and scoreboard bench for mem_load_arbiter
`timescale 1ns/1ps
module tb_mem_load_arbiter;

  localparam int IMEM_AW     = 14;
  localparam int DMEM_AW     = 14;
  localparam int TIMEOUT_CYC = 40;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               prog_req = 1'b0;
  logic               rx_valid = 1'b0;
  logic [7:0]         rx_byte = 8'h00;
  logic               cpu_mem_write = 1'b0;
  logic [31:0]        cpu_mem_addr = 32'h0;
  logic [31:0]        cpu_mem_wdata = 32'h0;
  logic               cpu_hold, cpu_restart, imem_we, dmem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_wdata, dmem_addr, dmem_wdata;
  logic               load_busy, load_done, load_err;

  mem_load_arbiter #(
    .IMEM_AW(IMEM_AW), .DMEM_AW(DMEM_AW), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clock(clock), .reset(reset), .prog_req(prog_req),
    .rx_valid(rx_valid), .rx_byte(rx_byte),
    .cpu_mem_write(cpu_mem_write), .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata),
    .cpu_hold(cpu_hold), .cpu_restart(cpu_restart),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .load_busy(load_busy), .load_done(load_done), .load_err(load_err)
  );

  always #5 clock = ~clock;

  typedef logic [64:0] wr_t;  // {is_imem, address, data}
  typedef struct {
    int             nb;
    logic [191:0]   stream;   // first byte is the most significant of the nb bytes
    int             nwr;
    logic [3:0][64:0] wr;
    logic           err;
  } vec_t;

  vec_t vecs [6];
  wr_t  exp_q [$];
  int   checks = 0;
  int   failures = 0;
  int   done_seen = 0;

  function automatic wr_t mk_wr(input logic im, input logic [31:0] a, input logic [31:0] d);
    return {im, a, d};
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic sb_pop(input logic im, input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL sb_unexpected_write actual=%h required=none", {im, a, d});
    end else begin
      e = exp_q.pop_front();
      if ({im, a, d} !== e) begin
        failures++;
        $display("FAIL sb_write actual=%h required=%h", {im, a, d}, e);
      end
    end
  endtask

  // Write monitor: loader writes are those seen while the CPU is held.
  always @(negedge clock) begin
    if (reset) begin
      if (imem_we) sb_pop(1'b1, 32'(imem_addr), imem_wdata);
      if (dmem_we && cpu_hold) sb_pop(1'b0, dmem_addr, dmem_wdata);
      if (load_done) begin
        done_seen++;
        check1("restart_with_done", cpu_restart, 1'b1);
        check1("hold_during_finish", cpu_hold, 1'b1);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_prog();
    prog_req = 1'b1;
    tick();
    prog_req = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    done_seen = 0;
    for (int k = 0; k < v.nwr; k++) exp_q.push_back(v.wr[k]);
    pulse_prog();
    check1($sformatf("vec%0d_start_hold", i), cpu_hold, 1'b1);
    check1($sformatf("vec%0d_start_busy", i), load_busy, 1'b1);
    check1($sformatf("vec%0d_start_err_clear", i), load_err, 1'b0);
    for (int k = 0; k < v.nb; k++) send_byte(v.stream[(v.nb-1-k)*8 +: 8]);
    for (int c = 0; c < 20; c++) begin
      if (v.err ? load_err : !cpu_hold) break;
      tick();
    end
    tick();
    tick();
    check1($sformatf("vec%0d_err", i), load_err, v.err);
    check1($sformatf("vec%0d_hold", i), cpu_hold, v.err);
    check32($sformatf("vec%0d_done_count", i), 32'(done_seen), v.err ? 32'd0 : 32'd1);
    check32($sformatf("vec%0d_sb_drain", i), 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0].nb = 16; vecs[0].stream = 192'h0200_7856_3412_EFBE_ADDE_0100_0403_0201;
    vecs[0].nwr = 3; vecs[0].err = 1'b0;
    vecs[0].wr[0] = mk_wr(1'b1, 32'h0, 32'h12345678);
    vecs[0].wr[1] = mk_wr(1'b1, 32'h1, 32'hDEADBEEF);
    vecs[0].wr[2] = mk_wr(1'b0, 32'h0, 32'h01020304);
    vecs[1].nb = 4;  vecs[1].stream = 192'h0000_0000; vecs[1].nwr = 0; vecs[1].err = 1'b0;
    vecs[2].nb = 12; vecs[2].stream = 192'h0000_0200_1122_3344_5566_7788;
    vecs[2].nwr = 2; vecs[2].err = 1'b0;
    vecs[2].wr[0] = mk_wr(1'b0, 32'h0, 32'h44332211);
    vecs[2].wr[1] = mk_wr(1'b0, 32'h4, 32'h88776655);
    vecs[3].nb = 2;  vecs[3].stream = 192'h0140; vecs[3].nwr = 0; vecs[3].err = 1'b1;
    vecs[4].nb = 8;  vecs[4].stream = 192'h0100_0102_0304_0140;
    vecs[4].nwr = 1; vecs[4].err = 1'b1;
    vecs[4].wr[0] = mk_wr(1'b1, 32'h0, 32'h04030201);
    vecs[5].nb = 8;  vecs[5].stream = 192'h0100_AABB_CCDD_0000;
    vecs[5].nwr = 1; vecs[5].err = 1'b0;
    vecs[5].wr[0] = mk_wr(1'b1, 32'h0, 32'hDDCCBBAA);

    // Reset state and combinational CPU pass-through.
    cpu_mem_write = 1'b1; cpu_mem_addr = 32'h10; cpu_mem_wdata = 32'h55;
    #2;
    check1("rst_dmem_we", dmem_we, 1'b1);
    check32("rst_dmem_addr", dmem_addr, 32'h10);
    check32("rst_dmem_wdata", dmem_wdata, 32'h55);
    check1("rst_cpu_hold", cpu_hold, 1'b0);
    check1("rst_cpu_restart", cpu_restart, 1'b0);
    check1("rst_imem_we", imem_we, 1'b0);
    check32("rst_imem_addr", 32'(imem_addr), 32'h0);
    check32("rst_imem_wdata", imem_wdata, 32'h0);
    check1("rst_load_busy", load_busy, 1'b0);
    check1("rst_load_done", load_done, 1'b0);
    check1("rst_load_err", load_err, 1'b0);
    tick(); tick();
    reset = 1'b1;
    tick();
    cpu_mem_addr = 32'h20; cpu_mem_wdata = 32'h66;
    #1;
    check32("run_pass_addr", dmem_addr, 32'h20);
    check32("run_pass_wdata", dmem_wdata, 32'h66);

    // CPU keeps requesting writes throughout; none may leak while held.
    cpu_mem_addr = 32'hBAD0; cpu_mem_wdata = 32'hBADBAD;
    for (int i = 0; i < 6; i++) run_vec(i);

    // Empty image: FINISH the cycle after the 4th header byte, hold falls next.
    pulse_prog();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    check1("empty_not_done_early", load_done, 1'b0);
    send_byte(8'h00);
    check1("empty_done", load_done, 1'b1);
    check1("empty_restart", cpu_restart, 1'b1);
    check1("empty_hold_in_finish", cpu_hold, 1'b1);
    tick();
    check1("empty_hold_released", cpu_hold, 1'b0);
    check1("empty_done_one_cycle", load_done, 1'b0);

    // Oversize count: ERR one cycle after the 2nd header byte; bytes then ignored.
    pulse_prog();
    send_byte(8'h01);
    send_byte(8'h40);
    check1("big_err", load_err, 1'b1);
    check1("big_hold", cpu_hold, 1'b1);
    check1("big_not_busy", load_busy, 1'b0);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h33); send_byte(8'h44);
    tick();
    check1("err_bytes_ignored", load_err, 1'b1);
    run_vec(5);

    // Idle timeout mid-word, then recovery with a full image.
    pulse_prog();
    send_byte(8'h02); send_byte(8'h00); send_byte(8'hAA); send_byte(8'hBB);
    repeat (TIMEOUT_CYC - 4) tick();
    check1("idle_no_err_early", load_err, 1'b0);
    check1("idle_still_busy", load_busy, 1'b1);
    for (int c = 0; c < 10; c++) begin
      if (load_err) break;
      tick();
    end
    check1("timeout_err", load_err, 1'b1);
    check1("timeout_hold", cpu_hold, 1'b1);
    run_vec(0);

    // Count of exactly 2^DMEM_AW is legal; reset after 5 data bytes.
    pulse_prog();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h40);
    check1("max_count_no_err", load_err, 1'b0);
    check1("max_count_busy", load_busy, 1'b1);
    exp_q.push_back(mk_wr(1'b0, 32'h0, 32'h44332211));
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    check1("we_at_t1", dmem_we, 1'b1);
    check32("we_addr_t1", dmem_addr, 32'h0);
    check32("we_data_t1", dmem_wdata, 32'h44332211);
    send_byte(8'h55);
    check1("we_one_cycle", dmem_we, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check1("midrst_hold", cpu_hold, 1'b0);
    check1("midrst_busy", load_busy, 1'b0);
    check1("midrst_done", load_done, 1'b0);
    check1("midrst_imem_we", imem_we, 1'b0);
    check32("midrst_imem_addr", 32'(imem_addr), 32'h0);
    check1("midrst_err", load_err, 1'b0);
    check32("midrst_dmem_pass", dmem_addr, 32'hBAD0);
    check32("midrst_sb_drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    tick();
    reset = 1'b1;
    tick();
    run_vec(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
